// File: rtl/temporizador_regressivo.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_regressivo
// Brief    : Loadable prescaled down-counter; stops at 0 and flags it (fim).
//            Macro RECARGA_AUTO_EN turns it into a periodic timer.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_regressivo #(
   parameter int M        = 8,
   parameter int N        = 4,
   parameter int PRESCALE = 1
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] valor,
   input  logic         conta,
   output logic [N-1:0] Q,
   output logic         fim,
   output logic         meio,
   output logic         tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [N-1:0]  c_max       = N'(M - 1);
   localparam logic [N-1:0]  c_meio      = N'(M / 2);
   localparam logic [N-1:0]  c_um        = N'(1);
   localparam logic [PW-1:0] c_presc_max = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      PRONTO   = 2'd0,
      CONTANDO = 2'd1,
      ESGOTADO = 2'd2
   } estado_t;

   estado_t       r_estado, w_estado_prox;
   logic [N-1:0]  r_q, w_q_prox;
   logic [PW-1:0] r_presc, w_presc_prox;
   logic          w_tick;
   logic          w_vence;

   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         r_estado <= PRONTO;
         r_q      <= c_max;
         r_presc  <= '0;
      end else begin
         r_estado <= w_estado_prox;
         r_q      <= w_q_prox;
         r_presc  <= w_presc_prox;
      end
   end

   // zera_s beats carrega, which beats a due tick
   always_comb begin
      w_estado_prox = r_estado;
      w_q_prox      = r_q;
      w_presc_prox  = r_presc;
      w_tick        = 1'b0;
      w_vence       = (r_presc == c_presc_max);
      if (zera_s) begin
         w_estado_prox = PRONTO;
         w_q_prox      = c_max;
         w_presc_prox  = '0;
      end else if (carrega) begin
         w_q_prox      = (valor > c_max) ? c_max : valor;
         w_presc_prox  = '0;
         w_estado_prox = (w_q_prox == '0) ? ESGOTADO : CONTANDO;
      end else if (conta) begin
         case (r_estado)
            PRONTO, CONTANDO: begin
               if (w_vence) begin
                  w_presc_prox  = '0;
                  w_tick        = 1'b1;
                  w_q_prox      = r_q - c_um;
                  w_estado_prox = (r_q == c_um) ? ESGOTADO : CONTANDO;
               end else begin
                  w_presc_prox  = r_presc + PW'(1);
                  w_estado_prox = CONTANDO;
               end
            end
            ESGOTADO: begin
`ifdef RECARGA_AUTO_EN
               if (w_vence) begin
                  w_presc_prox  = '0;
                  w_tick        = 1'b1;
                  w_q_prox      = c_max;
                  w_estado_prox = CONTANDO;
               end else begin
                  w_presc_prox  = r_presc + PW'(1);
               end
`else
               w_presc_prox = '0;
`endif
            end
            default: begin
               w_estado_prox = PRONTO;
               w_q_prox      = c_max;
               w_presc_prox  = '0;
            end
         endcase
      end
   end

   assign Q    = r_q;
   assign fim  = (r_q == '0);
   assign meio = (r_q == c_meio);
   // Gated so tick is guaranteed low while the async reset is held
   assign tick = w_tick & zera_as_n;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_regressivo.sv
`default_nettype none
// ============================================================================
// Module   : tb_temporizador_regressivo
// Brief    : Randomized + directed bench for temporizador_regressivo with a
//            behavioural count/phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temporizador_regressivo;

   localparam int M = 8;
   localparam int N = 4;
   localparam int P = 3;
`ifdef RECARGA_AUTO_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         zera_as_n = 1'b0;
   logic         zera_s = 1'b0;
   logic         carrega = 1'b0;
   logic [N-1:0] valor = '0;
   logic         conta = 1'b0;
   logic [N-1:0] Q;
   logic         fim;
   logic         meio;
   logic         tick;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b1;

   int m_q = M - 1;
   int m_ph = 0;

   temporizador_regressivo #(.M(M), .N(N), .PRESCALE(P)) dut (
      .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s),
      .carrega(carrega), .valor(valor), .conta(conta),
      .Q(Q), .fim(fim), .meio(meio), .tick(tick)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_tick();
      return zera_as_n && !zera_s && !carrega && conta &&
             (m_q > 0 || AUTO) && (m_ph == P - 1);
   endfunction

   // Model: count value plus number of enabled cycles since the last step
   always @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         m_q = M - 1; m_ph = 0;
      end else if (zera_s) begin
         m_q = M - 1; m_ph = 0;
      end else if (carrega) begin
         m_q = (int'(valor) > M - 1) ? M - 1 : int'(valor);
         m_ph = 0;
      end else if (conta && (m_q > 0 || AUTO)) begin
         m_ph++;
         if (m_ph == P) begin
            m_ph = 0;
            m_q = (m_q == 0) ? M - 1 : m_q - 1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("q", 32'(Q), 32'(m_q));
         check("fim", 32'(fim), 32'(m_q == 0));
         check("meio", 32'(meio), 32'(m_q == M / 2));
         check("tick", 32'(tick), 32'(exp_tick()));
      end
   end

   task automatic cyc(input bit c, input bit car, input int v, input bit zs);
      conta = c; carrega = car; valor = N'(v); zera_s = zs;
      @(posedge clock); #1;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1 zera_as_n = 1'b1;
      check("rst_q", 32'(Q), 32'd7);
      check("rst_fim", 32'(fim), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);

      // full countdown from reset
      for (int k = 1; k <= 7; k++) begin
         repeat (P) cyc(1, 0, 0, 0);
         check("down_q", 32'(Q), 32'(7 - k));
      end
      check("down_fim21", 32'(fim), 32'd1);
`ifdef RECARGA_AUTO_EN
      repeat (2) cyc(1, 0, 0, 0);
      check("auto_hold", 32'(Q), 32'd0);
      cyc(1, 0, 0, 0);
      check("auto_reload", 32'(Q), 32'd7);
`else
      repeat (30) cyc(1, 0, 0, 0);
      check("stay_zero", 32'(Q), 32'd0);
`endif

      // async reset in the middle of a count
      cyc(0, 0, 0, 1);
      repeat (9) cyc(1, 0, 0, 0);
      check("mid_q4", 32'(Q), 32'd4);
      cyc(1, 0, 0, 0);
      #1 zera_as_n = 1'b0;
      #1;
      check("async_q", 32'(Q), 32'd7);
      check("async_fim", 32'(fim), 32'd0);
      check("async_tick", 32'(tick), 32'd0);
      #4 zera_as_n = 1'b1;
      @(posedge clock); #1;
      repeat (P - 1) cyc(1, 0, 0, 0);
      check("restart_q", 32'(Q), 32'd6);

      // loads: saturation, short count, load of zero
      cyc(0, 1, 12, 0);
      check("load_sat", 32'(Q), 32'd7);
      cyc(0, 1, 3, 0);
      repeat (9) cyc(1, 0, 0, 0);
      check("load3_fim", 32'(fim), 32'd1);
      cyc(0, 1, 5, 0);
      cyc(1, 1, 0, 0);
      check("load0_q", 32'(Q), 32'd0);
      check("load0_fim", 32'(fim), 32'd1);

      // pause and resume
      cyc(0, 0, 0, 1);
      repeat (6) cyc(1, 0, 0, 0);
      check("pause_pre", 32'(Q), 32'd5);
      repeat (20) cyc(0, 0, 0, 0);
      check("pause_hold", 32'(Q), 32'd5);
      repeat (15) cyc(1, 0, 0, 0);
      check("resume_q", 32'(Q), 32'd0);

      // zera_s wins over carrega
      cyc(1, 1, 2, 1);
      check("zs_over_load", 32'(Q), 32'd7);

      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 14) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
